serial_sub4_sar: RTL and testbench

SERIAL_SUB4_SAR -- requirements
Module: serial_sub4_sar

---
 rtl/fulladd4_sar_pkg.sv | 12 +
 rtl/full_sub1_sar.sv | 13 +
 rtl/serial_sub4_sar.sv | 108 ++++++++++
 tb/tb_serial_sub4_sar.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fulladd4_sar_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package fulladd4_sar_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_sub1_sar.sv
// One-bit full subtractor: difference and borrow-out from a, b and borrow-in.
module full_sub1_sar (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub4_sar.sv
// Bit-serial subtractor: computes A - B - B_IN one bit per clock, LSB first,
// and publishes DIFF/B_OUT together with a one-cycle DONE pulse.
module serial_sub4_sar
    import fulladd4_sar_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             B_OUT
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bor_q, bor_d;
    logic             bout_q, bout_d;
    logic             bit_d, bit_bout;
    logic [WIDTH-1:0] dsr_next;

    full_sub1_sar u_bit (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Difference bits enter at the MSB so the word is aligned after the last shift.
    assign dsr_next = (dsr_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        dsr_d   = dsr_q;
        bor_d   = bor_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    bor_d   = B_IN;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bor_d = bit_bout;
                dsr_d = dsr_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = dsr_next;
                    bout_d  = bit_bout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dsr_q   <= '0;
            bor_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dsr_q   <= dsr_d;
            bor_q   <= bor_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign BUSY  = (state_q != ST_IDLE);
    assign DONE  = (state_q == ST_DONE);
    assign DIFF  = diff_q;
    assign B_OUT = bout_q;

endmodule

// File: tb/tb_serial_sub4_sar.sv
// Randomized and directed bench for serial_sub4_sar against an arithmetic reference model.
module tb_serial_sub4_sar;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         B_IN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] DIFF;
    logic         B_OUT;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] last_d = '0;
    logic         last_b = 1'b0;

    serial_sub4_sar #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .B_IN  (B_IN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DIFF  (DIFF),
        .B_OUT (B_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction, wrapped mod 2^W; borrow when negative.
    function automatic int ref_diff(input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        return ((r % M) + M) % M;
    endfunction

    function automatic int ref_bout(input int a, input int b, input int bin);
        return (a < b + bin) ? 1 : 0;
    endfunction

    // Called at a negedge with the DUT idle; ign>0 pulses a (must-be-ignored) START
    // at that cycle of the operation.
    task automatic run_op(input int a, input int b, input int bin, input int ign);
        int  ed, eb, n;
        bit  seen;
        ed = ref_diff(a, b, bin);
        eb = ref_bout(a, b, bin);
        A = W'(a); B = W'(b); B_IN = bin[0]; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 4 * W + 8) begin
            if (DONE) begin
                seen = 1'b1;
            end else begin
                check("busy_shift", BUSY, 1);
                check("hold_diff", DIFF, last_d);
                check("hold_bout", B_OUT, last_b);
                A = W'($urandom); B = W'($urandom); B_IN = 1'($urandom);
                START = (n == ign);
                @(negedge CLK);
                n++;
            end
        end
        START = 1'b0;
        check("done_seen", seen, 1);
        if (seen) begin
            check("latency", n, W + 1);
            check("diff", DIFF, ed);
            check("bout", B_OUT, eb);
            check("busy_done", BUSY, 1);
            last_d = W'(ed);
            last_b = eb[0];
            // START during the DONE cycle must not launch a new operation.
            START = 1'b1; A = W'($urandom); B = W'($urandom); B_IN = 1'($urandom);
            @(negedge CLK);
            START = 1'b0;
            check("done_pulse", DONE, 0);
            check("idle_busy", BUSY, 0);
            check("keep_diff", DIFF, ed);
            check("keep_bout", B_OUT, eb);
        end
    endtask

    initial begin
        int t, j, p, base, opa, opb, opc;
        int qa[$], qb[$], qc[$];
        RST = 1'b1; START = 1'b0; A = '0; B = '0; B_IN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_diff", DIFF, 0);
        check("rst_bout", B_OUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        RST = 1'b0;

        // START accepted on the very first edge after reset release.
        run_op(9, 5, 0, 0);
        run_op(3, 4, 0, 0);
        run_op(10, 15, 1, 0);
        run_op(0, 0, 1, 0);
        run_op(7, 2, 0, 2);

        // Reset in the second SHIFT cycle aborts the operation.
        A = 4'd12; B = 4'd3; B_IN = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("abort_diff", DIFF, 0);
        check("abort_bout", B_OUT, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        last_d = '0;
        last_b = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("abort_nodone", DONE, 0);
        end
        run_op(12, 3, 0, 0);

        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
                   int'($urandom_range(1)), int'($urandom_range(W + 1)));
        end

        // START held high: captures every W+2 cycles, operands change every cycle.
        p = W + 2;
        for (t = 0; t <= 3 * p; t++) begin
            if (t > 0) begin
                j = (t - 1) / p;
                if ((t - 1) % p == W && j < 3) begin
                    base = j * p;
                    check("b2b_done", DONE, 1);
                    check("b2b_diff", DIFF, ref_diff(qa[base], qb[base], qc[base]));
                    check("b2b_bout", B_OUT, ref_bout(qa[base], qb[base], qc[base]));
                end else begin
                    check("b2b_nodone", DONE, 0);
                end
            end
            opa = int'($urandom_range(M - 1));
            opb = int'($urandom_range(M - 1));
            opc = int'($urandom_range(1));
            qa.push_back(opa); qb.push_back(opb); qc.push_back(opc);
            A = W'(opa); B = W'(opb); B_IN = opc[0]; START = (t < 3 * p - 1);
            @(negedge CLK);
        end
        START = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
